// File: rtl/mac_seq_ctrl_if.sv
// Handshake bundle for mac_seq_ctrl: job request, operand stream and result.
// The master side is the job/operand source and result consumer; the slave side is the sequencer.
interface mac_seq_ctrl_if #(
   parameter int unsigned DW    = 4,
   parameter int unsigned AW    = 9,
   parameter int unsigned LEN_W = 4
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in1;
   logic [DW-1:0]    in2;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out;
   logic             ovf;

   modport master (
      output start, len, in_valid, in1, in2, out_ready,
      input  busy, in_ready, out_valid, out, ovf
   );

   modport slave (
      input  start, len, in_valid, in1, in2, out_ready,
      output busy, in_ready, out_valid, out, ovf
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer around a 2-stage multiply-accumulate datapath.
// Optional MAC_SEQ_SAT_EN: saturating accumulator with sticky overflow flag.
module mac_seq_ctrl #(
   parameter int unsigned DW    = 4,
   parameter int unsigned AW    = 9,
   parameter int unsigned LEN_W = 4
) (
   input  logic           clock,
   input  logic           reset,
   mac_seq_ctrl_if.slave  bus
);

   localparam int unsigned PW = 2 * DW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] count;
   logic [DW-1:0]    op1;
   logic [DW-1:0]    op2;
   logic             pipe_valid;
   logic [AW-1:0]    acc;

   logic             busy_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic             clear_c;
   logic             accept_c;
   logic [PW-1:0]    prod_c;
   logic [AW-1:0]    acc_nxt_c;

   // Next-state and per-cycle control strobes
   always_comb begin
      state_nxt = state;
      clear_c   = 1'b0;
      accept_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               clear_c   = 1'b1;
               state_nxt = (bus.len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            accept_c = bus.in_valid;
            if (bus.in_valid && (count == len_q - LEN_W'(1))) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_nxt = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; handshake outputs are flopped from the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         busy_q      <= (state_nxt != S_IDLE);
         in_ready_q  <= (state_nxt == S_LOAD);
         out_valid_q <= (state_nxt == S_DONE);
      end
   end

   assign prod_c = PW'(op1) * PW'(op2);

`ifdef MAC_SEQ_SAT_EN
   logic [AW:0] sum_c;
   logic        sat_c;
   logic        ovf_q;

   // One extra carry bit detects crossing 2^AW; clamp to all-ones
   always_comb begin
      sum_c     = {1'b0, acc} + (AW + 1)'(prod_c);
      sat_c     = sum_c[AW];
      acc_nxt_c = sat_c ? {AW{1'b1}} : sum_c[AW-1:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (clear_c) begin
         ovf_q <= 1'b0;
      end else if (pipe_valid && sat_c) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.ovf = ovf_q;
`else
   always_comb begin
      acc_nxt_c = acc + AW'(prod_c);
   end

   assign bus.ovf = 1'b0;
`endif

   // Operand stage, pair counter and accumulator
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_q      <= '0;
         count      <= '0;
         op1        <= '0;
         op2        <= '0;
         pipe_valid <= 1'b0;
         acc        <= '0;
      end else begin
         pipe_valid <= accept_c;
         if (accept_c) begin
            op1 <= bus.in1;
            op2 <= bus.in2;
         end
         if (clear_c) begin
            len_q <= bus.len;
            count <= '0;
         end else if (accept_c) begin
            count <= count + LEN_W'(1);
         end
         if (clear_c) begin
            acc <= '0;
         end else if (pipe_valid) begin
            acc <= acc_nxt_c;
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: expected job results are queued at start,
// a negedge monitor compares every presented result against the queue head.
module tb_mac_seq_ctrl;

   localparam int unsigned DW    = 4;
   localparam int unsigned AW    = 9;
   localparam int unsigned LEN_W = 4;

   typedef struct packed {
      logic [AW-1:0] out;
      logic          ovf;
   } res_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   mac_seq_ctrl_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) bus ();

   mac_seq_ctrl #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t exp_q[$];
   int   pa[16];
   int   pb[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a dot product is the plain sum of products, wrapped or clamped
   function automatic res_t model(input int unsigned s);
      res_t r;
`ifdef MAC_SEQ_SAT_EN
      if (s >= (32'd1 << AW)) begin
         r.out = {AW{1'b1}};
         r.ovf = 1'b1;
      end else begin
         r.out = AW'(s);
         r.ovf = 1'b0;
      end
`else
      r.out = AW'(s % (32'd1 << AW));
      r.ovf = 1'b0;
`endif
      return r;
   endfunction

   function automatic res_t job_model(input int n);
      int unsigned s = 0;
      for (int i = 0; i < n; i++) s += pa[i] * pb[i];
      return model(s);
   endfunction

   // Monitor: every cycle a result is presented it must match the queue head
   always @(negedge clock) begin
      if (reset && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            check("result_out", bus.out, exp_q[0].out);
            check("result_ovf", bus.ovf, exp_q[0].ovf);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_pair(input int a, input int b);
      logic rdy;
      int   t = 0;
      bus.in_valid = 1'b1;
      bus.in1      = DW'(a);
      bus.in2      = DW'(b);
      do begin
         @(negedge clock);
         rdy = bus.in_ready;
         @(posedge clock);
         #1;
         t++;
      end while (!rdy && t < 100);
      if (!rdy) check("in_ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      bus.in1      = DW'($urandom);
      bus.in2      = DW'($urandom);
   endtask

   // Waits for the scoreboard to drain, then expects a return to idle
   task automatic wait_result();
      int t = 0;
      while (exp_q.size() != 0 && t < 60) begin
         @(posedge clock);
         t++;
      end
      if (exp_q.size() != 0) begin
         check("result_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end
      @(negedge clock);
      check("idle_out_valid", bus.out_valid, 32'd0);
      check("idle_busy", bus.busy, 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   // Full job: start, stream pairs with gaps, check latency, hold result, consume
   task automatic run_job(input int n, input int gap, input int hold);
      res_t r = job_model(n);
      @(posedge clock);
      #1;
      bus.out_ready = (hold == 0);
      bus.start     = 1'b1;
      bus.len       = LEN_W'(n);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.len   = LEN_W'($urandom);
      exp_q.push_back(r);
      if (n == 0) begin
         @(negedge clock);
         check("len0_valid", bus.out_valid, 32'd1);
         check("len0_in_ready", bus.in_ready, 32'd0);
      end else begin
         for (int i = 0; i < n; i++) begin
            send_pair(pa[i], pb[i]);
            if (i < n - 1) repeat (gap) @(posedge clock);
            if (i < n - 1) #1;
         end
         // operands offered while not ready must never be captured
         bus.in_valid = 1'b1;
         bus.in1      = DW'(15);
         bus.in2      = DW'(15);
         @(negedge clock);
         check("drain_out_valid", bus.out_valid, 32'd0);
         check("drain_in_ready", bus.in_ready, 32'd0);
         @(negedge clock);
         check("latency_out_valid", bus.out_valid, 32'd1);
         check("done_in_ready", bus.in_ready, 32'd0);
      end
      for (int j = 1; j < hold; j++) begin
         @(negedge clock);
         check("hold_out_valid", bus.out_valid, 32'd1);
         check("hold_in_ready", bus.in_ready, 32'd0);
      end
      if (hold > 0) begin
         @(posedge clock);
         #1;
         bus.out_ready = 1'b1;
      end
      wait_result();
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in1       = '0;
      bus.in2       = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_busy", bus.busy, 32'd0);
      check("rst_in_ready", bus.in_ready, 32'd0);
      check("rst_out_valid", bus.out_valid, 32'd0);
      check("rst_out", bus.out, 32'd0);
      check("rst_ovf", bus.ovf, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Basic job, back-to-back, immediate consume
      pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
      run_job(3, 0, 0);
      // Same job with input gaps and a stalled consumer
      run_job(3, 2, 5);
      // Empty job
      run_job(0, 0, 0);
      // Overflowing job, then a small job to show the flag clears
      pa[0] = 15; pb[0] = 15; pa[1] = 15; pb[1] = 15; pa[2] = 15; pb[2] = 15;
      run_job(3, 0, 0);
      pa[0] = 1; pb[0] = 1;
      run_job(1, 0, 0);

      // Abort mid-job with reset, then check no residue leaks into the next job
      @(posedge clock);
      #1;
      bus.start = 1'b1;
      bus.len   = LEN_W'(3);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      send_pair(7, 7);
      send_pair(3, 3);
      @(negedge clock);
      check("pre_abort_busy", bus.busy, 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("abort_busy", bus.busy, 32'd0);
      check("abort_in_ready", bus.in_ready, 32'd0);
      check("abort_out_valid", bus.out_valid, 32'd0);
      check("abort_out", bus.out, 32'd0);
      check("abort_ovf", bus.ovf, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      pa[0] = 2; pb[0] = 3;
      run_job(1, 0, 0);

      // start pulses during LOAD and DONE are ignored
      @(posedge clock);
      #1;
      bus.start = 1'b1;
      bus.len   = LEN_W'(2);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      pa[0] = 4; pb[0] = 1; pa[1] = 2; pb[1] = 2;
      exp_q.push_back(job_model(2));
      send_pair(4, 1);
      bus.start = 1'b1;
      bus.len   = LEN_W'(7);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      send_pair(2, 2);
      bus.out_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("ign_done_valid", bus.out_valid, 32'd1);
      @(posedge clock);
      #1;
      bus.start = 1'b1;
      bus.len   = LEN_W'(3);
      @(posedge clock);
      #1;
      bus.out_ready = 1'b1;
      bus.len       = LEN_W'(2);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      @(negedge clock);
      check("ret_idle_busy", bus.busy, 32'd0);
      check("ret_idle_out_valid", bus.out_valid, 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);
      // New job launched on the first IDLE cycle
      bus.start = 1'b1;
      bus.len   = LEN_W'(2);
      pa[0] = 1; pb[0] = 1; pa[1] = 2; pb[1] = 2;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      exp_q.push_back(job_model(2));
      send_pair(1, 1);
      send_pair(2, 2);
      wait_result();

      // Randomized jobs
      for (int k = 0; k < 24; k++) begin
         int n = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            pa[i] = $urandom_range(0, 15);
            pb[i] = $urandom_range(0, 15);
         end
         run_job(n, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
